serial_tx: RTL
==============

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter: DATA_W, default 8, payload bits per frame; legal range 1..32.
REQ-002 Parameter: CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 2..65535.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rstn  input  1  asynchronous reset, active low.
REQ-005 Port: in_data  input  DATA_W  parallel payload to transmit.
REQ-006 Port: in_valid  input  1  in_data is valid this cycle.
REQ-007 Port: in_ready  output  1  block can accept a payload this cycle.
REQ-008 Port: txd  output  1  serial line; idle high.
REQ-009 Port: busy  output  1  a frame is in progress.
REQ-010 Port: tx_done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-011 The block SHALL run one FSM with states IDLE, START, DATA, STOP.
REQ-012 In IDLE, the block SHALL drive in_ready=1, busy=0 and txd=1.
REQ-013 In IDLE, an accept (in_valid=1 and in_ready=1 on a rising edge) SHALL latch in_data into an internal shift register and move the FSM to START.
REQ-014 In-data changes after the accept SHALL have no effect on the frame in progress.
REQ-015 In START, DATA and STOP, the block SHALL drive in_ready=0 and busy=1; in_valid SHALL be ignored in these states.
REQ-016 START SHALL drive txd=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA SHALL send DATA_W bits LSB first, each held on txd for exactly CLKS_PER_BIT cycles.
REQ-018 After the last data bit, DATA SHALL go to STOP.
REQ-019 STOP SHALL drive txd=1 for exactly CLKS_PER_BIT cycles.
REQ-020 tx_done SHALL be 1 in the last STOP cycle and 0 in all other cycles.
REQ-021 After the last STOP cycle, the FSM SHALL return to IDLE.
REQ-022 txd SHALL go low in the first clk cycle after the accept edge.
REQ-023 Frame length SHALL be exactly (DATA_W+2)*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle inclusive.
REQ-024 Back-to-back frames: at least one IDLE cycle (txd=1, in_ready=1) SHALL separate consecutive frames; a payload held valid SHALL be accepted in that IDLE cycle.
REQ-025 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.
REQ-026 The data-bit index SHALL count 0..DATA_W-1 and SHALL NOT wrap within a frame.
REQ-027 txd SHALL be driven from a register, so it is glitch-free.
REQ-028 in_ready, busy and tx_done SHALL be decoded from registered state only, with no combinational path from in_valid.

Reset
REQ-029 While rstn=0, the block SHALL immediately, without waiting for clk, force: FSM=IDLE, txd=1, in_ready=0, busy=0, tx_done=0, counters=0, shift register=0.
REQ-030 in_ready SHALL rise in the first rising clk edge after rstn deasserts.
REQ-031 Reset asserted mid-frame SHALL abort the frame, return txd to 1 asynchronously, and leave no partial frame pending after reset.
REQ-032 A payload presented during reset SHALL NOT be accepted.

Verification (DATA_W=8, CLKS_PER_BIT=4)
REQ-033 Single frame: accept in_data=0xA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles; 40-cycle frame; tx_done pulses once in cycle 40; in_ready=0 throughout the frame.
REQ-034 Back-to-back: in_valid held high with 0x00 then 0xFF -> two 40-cycle frames separated by exactly one IDLE cycle with txd=1; data bits all 0, then all 1.
REQ-035 Data stability: change in_data from 0x3C to 0xC3 one cycle after the accept -> the transmitted bits are 0x3C LSB first (0,0,1,1,1,1,0,0).
REQ-036 Reset mid-frame: assert rstn=0 during data bit 3 -> txd=1 and busy=0 with no clk edge required; after release, in_ready=1 on the next edge; a new frame of 0x81 transmits correctly.
REQ-037 Ignored input: pulse in_valid with 0x55 during the STOP of a prior frame -> 0x55 is not transmitted; only the prior frame appears on txd.
REQ-038 Minimum bit period: CLKS_PER_BIT=2, DATA_W=1, in_data=1 -> txd sequence 0,0,1,1,1,1; 6-cycle frame; tx_done pulses in cycle 6.

Source files
------------

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx -- single-clock asynchronous-style serial transmitter.
//
// A payload accepted on the in_valid/in_ready handshake is framed as one start
// bit (0), DATA_W data bits LSB first and one stop bit (1), each held on txd for
// CLKS_PER_BIT clk cycles. At least one IDLE cycle separates consecutive frames.
//
// Ports:
//   clk       input   system clock, all state changes on rising edge
//   rstn      input   asynchronous reset, active low
//   in_data   input   [DATA_W-1:0] payload, latched on accept
//   in_valid  input   payload valid
//   in_ready  output  payload can be accepted this cycle (IDLE only)
//   txd       output  registered serial line, idle high
//   busy      output  frame in progress
//   tx_done   output  one-cycle pulse in the last stop-bit cycle
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | line high, waiting for in_valid
// START | start bit (txd=0) for CLKS_PER_BIT cycles
// DATA  | DATA_W payload bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (txd=1); tx_done in its last cycle
// -----------------------------------------------------------------------------
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              txd,
    output logic              busy,
    output logic              tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shreg;
    logic              txd_q;
    logic              armed;
    logic              accept;
    logic              bit_end;
    logic              last_bit;

    assign accept   = in_valid && in_ready;
    assign bit_end  = (cnt == CNT_LAST);
    assign last_bit = (idx == IDX_LAST);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)              state_nxt = START;
            START:   if (bit_end)             state_nxt = DATA;
            DATA:    if (bit_end && last_bit) state_nxt = STOP;
            STOP:    if (bit_end)             state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state only. armed keeps in_ready low
    // until the first clock edge after reset release.
    always_comb begin
        in_ready = (state == IDLE) && armed;
        busy     = (state != IDLE);
        tx_done  = (state == STOP) && bit_end;
        txd      = txd_q;
    end

    // Datapath: bit-period counter, bit index, shift register, line register.
    // shreg[0] always holds the next data bit to go out, so txd_q is loaded one
    // edge ahead of each bit boundary and the line stays glitch-free.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            txd_q <= 1'b1;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (accept) begin
                        shreg <= in_data;
                        txd_q <= 1'b0;
                    end
                end
                START: begin
                    cnt <= bit_end ? '0 : cnt + 1'b1;
                    if (bit_end) begin
                        txd_q <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
                DATA: begin
                    cnt <= bit_end ? '0 : cnt + 1'b1;
                    if (bit_end) begin
                        if (last_bit) begin
                            txd_q <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            txd_q <= shreg[0];
                            shreg <= shreg >> 1;
                        end
                    end
                end
                STOP: begin
                    cnt   <= bit_end ? '0 : cnt + 1'b1;
                    txd_q <= 1'b1;
                end
                default: begin
                    cnt   <= '0;
                    txd_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
